instr_decoder: RTL and testbench



---
 rtl/cpu_pkg.sv | 24 ++
 rtl/instr_decoder_if.sv | 29 ++
 rtl/instr_fields.sv | 27 ++
 rtl/instr_decoder.sv | 143 ++++++++++++++
 tb/tb_instr_decoder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: encoded opcodes, instruction field positions and decoder FSM states.
package cpu_pkg;

    localparam int OPC_W   = 6;
    localparam int REG_W   = 3;
    localparam int INSTR_W = 16;

    // Field positions (LSB of each field) within a raw instruction word
    localparam int OPC_LSB = 10;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 1;

    localparam logic [OPC_W-1:0] OP_GHA  = 6'b010101;
    localparam logic [OPC_W-1:0] OP_GHS  = 6'b010110;
    localparam logic [OPC_W-1:0] OP_MUL  = 6'b100001;
    localparam logic [OPC_W-1:0] OP_LAST = 6'b111000;

    typedef enum logic {
        RUN    = 1'b0,
        SECOND = 1'b1
    } dec_state_t;

endpackage

// File: rtl/instr_decoder_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle; the decoder uses the slave view.
interface instr_decoder_if;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic        ir_ready;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instruction;
    logic [5:0]  dec_opcode;
    logic [2:0]  dec_rd;
    logic [2:0]  dec_rs1;
    logic [2:0]  dec_rs2;
    logic        dec_uop;
    logic        dec_writes_status;
    logic        illegal_op;

    modport master (
        output ir_valid, ir_data, flush, dec_ready,
        input  ir_ready, dec_valid, dec_instruction, dec_opcode, dec_rd,
               dec_rs1, dec_rs2, dec_uop, dec_writes_status, illegal_op
    );

    modport slave (
        input  ir_valid, ir_data, flush, dec_ready,
        output ir_ready, dec_valid, dec_instruction, dec_opcode, dec_rd,
               dec_rs1, dec_rs2, dec_uop, dec_writes_status, illegal_op
    );
endinterface

// File: rtl/instr_fields.sv
// Combinational field extraction, opcode legality and status-write decode for one instruction.
module instr_fields
    import cpu_pkg::*;
#(
    parameter int NUM_OPCODES = 57
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic               legal,
    output logic               writes_status
);

    localparam logic [OPC_W:0] OPC_LIMIT = (OPC_W+1)'(NUM_OPCODES);

    // Bit ops reuse [3:0] as a bit offset; the consumer reads it from the raw word.
    assign opcode = instr[OPC_LSB +: OPC_W];
    assign rd     = instr[RD_LSB  +: REG_W];
    assign rs1    = instr[RS1_LSB +: REG_W];
    assign rs2    = instr[RS2_LSB +: REG_W];

    assign legal         = ({1'b0, opcode} < OPC_LIMIT);
    assign writes_status = (opcode != OP_GHA) && (opcode != OP_GHS);

endmodule

// File: rtl/instr_decoder.sv
// Decode stage: one-entry output register, MUL micro-op split, illegal-opcode drop and flush.
// Optional feature macro: DECODER_MUL_SPLIT_EN (MUL issues as two micro-ops when defined).
module instr_decoder
    import cpu_pkg::*;
#(
    parameter int NUM_OPCODES = 57
) (
    input  logic            clk,
    input  logic            reset_n,
    instr_decoder_if.slave  bus
);

    logic [OPC_W-1:0] fld_opcode;
    logic [REG_W-1:0] fld_rd, fld_rs1, fld_rs2;
    logic             fld_legal, fld_writes_status;

    instr_fields #(.NUM_OPCODES(NUM_OPCODES)) u_fields (
        .instr         (bus.ir_data),
        .opcode        (fld_opcode),
        .rd            (fld_rd),
        .rs1           (fld_rs1),
        .rs2           (fld_rs2),
        .legal         (fld_legal),
        .writes_status (fld_writes_status)
    );

    logic               valid_reg,   valid_next;
    logic [INSTR_W-1:0] instr_reg,   instr_next;
    logic [OPC_W-1:0]   opcode_reg,  opcode_next;
    logic [REG_W-1:0]   rd_reg,      rd_next;
    logic [REG_W-1:0]   rs1_reg,     rs1_next;
    logic [REG_W-1:0]   rs2_reg,     rs2_next;
    logic               ws_reg,      ws_next;
    logic               illegal_reg, illegal_next;
    logic               in_run, ready, accept, consume;

`ifdef DECODER_MUL_SPLIT_EN
    dec_state_t state_reg, state_next;
    logic       uop_reg,   uop_next;
    assign in_run = (state_reg == RUN);
`else
    assign in_run = 1'b1;
`endif

    assign ready   = reset_n & ~bus.flush & in_run & (~valid_reg | bus.dec_ready);
    assign accept  = bus.ir_valid & ready;
    assign consume = valid_reg & bus.dec_ready;

    always_comb begin
        valid_next   = valid_reg;
        instr_next   = instr_reg;
        opcode_next  = opcode_reg;
        rd_next      = rd_reg;
        rs1_next     = rs1_reg;
        rs2_next     = rs2_reg;
        ws_next      = ws_reg;
        illegal_next = 1'b0;
`ifdef DECODER_MUL_SPLIT_EN
        state_next   = state_reg;
        uop_next     = uop_reg;
`endif
        if (bus.flush) begin
            valid_next = 1'b0;
`ifdef DECODER_MUL_SPLIT_EN
            state_next = RUN;
`endif
        end else begin
            illegal_next = accept & ~fld_legal;
            if (accept && fld_legal) begin
                valid_next  = 1'b1;
                instr_next  = bus.ir_data;
                opcode_next = fld_opcode;
                rd_next     = fld_rd;
                rs1_next    = fld_rs1;
                rs2_next    = fld_rs2;
                ws_next     = fld_writes_status;
`ifdef DECODER_MUL_SPLIT_EN
                uop_next    = 1'b0;
                state_next  = (fld_opcode == OP_MUL) ? SECOND : RUN;
`endif
            end else if (consume) begin
`ifdef DECODER_MUL_SPLIT_EN
                // High half of MUL targets the next register, wrapping 7 -> 0
                if (state_reg == SECOND && !uop_reg) begin
                    uop_next = 1'b1;
                    rd_next  = rd_reg + 3'd1;
                end else begin
                    valid_next = 1'b0;
                    state_next = RUN;
                end
`else
                valid_next = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_reg   <= 1'b0;
            instr_reg   <= '0;
            opcode_reg  <= '0;
            rd_reg      <= '0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            ws_reg      <= 1'b0;
            illegal_reg <= 1'b0;
`ifdef DECODER_MUL_SPLIT_EN
            state_reg   <= RUN;
            uop_reg     <= 1'b0;
`endif
        end else begin
            valid_reg   <= valid_next;
            instr_reg   <= instr_next;
            opcode_reg  <= opcode_next;
            rd_reg      <= rd_next;
            rs1_reg     <= rs1_next;
            rs2_reg     <= rs2_next;
            ws_reg      <= ws_next;
            illegal_reg <= illegal_next;
`ifdef DECODER_MUL_SPLIT_EN
            state_reg   <= state_next;
            uop_reg     <= uop_next;
`endif
        end
    end

    assign bus.ir_ready          = ready;
    assign bus.dec_valid         = valid_reg;
    assign bus.dec_instruction   = instr_reg;
    assign bus.dec_opcode        = opcode_reg;
    assign bus.dec_rd            = rd_reg;
    assign bus.dec_rs1           = rs1_reg;
    assign bus.dec_rs2           = rs2_reg;
    assign bus.dec_writes_status = ws_reg;
    assign bus.illegal_op        = illegal_reg;
`ifdef DECODER_MUL_SPLIT_EN
    assign bus.dec_uop           = uop_reg;
`else
    assign bus.dec_uop           = 1'b0;
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// Directed self-checking bench for instr_decoder; MUL expectations follow DECODER_MUL_SPLIT_EN.
module tb_instr_decoder;

    logic clk = 1'b0;
    logic reset_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    instr_decoder_if dif ();

    instr_decoder #(.NUM_OPCODES(57)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; dif.ir_valid = 1'b1; dif.ir_data = 16'h4698;
        dif.flush = 1'b0; dif.dec_ready = 1'b1;
        tick(); tick();
        tests_run++; if (dif.ir_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ir_ready: got %0b want 0", dif.ir_ready); end
        tests_run++; if (dif.dec_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_dec_valid: got %0b want 0", dif.dec_valid); end
        tests_run++; if (dif.dec_instruction !== 16'h0000) begin tests_failed++; $display("FAIL rst_instr: got %h want 0000", dif.dec_instruction); end
        tests_run++; if (dif.dec_writes_status !== 1'b0) begin tests_failed++; $display("FAIL rst_ws: got %0b want 0", dif.dec_writes_status); end
        tests_run++; if (dif.illegal_op !== 1'b0) begin tests_failed++; $display("FAIL rst_illegal: got %0b want 0", dif.illegal_op); end
        tests_run++; if (dif.dec_uop !== 1'b0) begin tests_failed++; $display("FAIL rst_uop: got %0b want 0", dif.dec_uop); end
        reset_n = 1'b1; dif.ir_valid = 1'b0;
        #1;
        tests_run++; if (dif.ir_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_release_ready: got %0b want 1", dif.ir_ready); end
        $display("[TB] reset: outputs cleared, ir_ready=%0b after release", dif.ir_ready);
    endtask

    task automatic test_add();
        dif.ir_data = 16'h4698; dif.ir_valid = 1'b1; dif.dec_ready = 1'b1;
        #1;
        tests_run++; if (dif.ir_ready !== 1'b1) begin tests_failed++; $display("FAIL add_ready: got %0b want 1", dif.ir_ready); end
        tick();
        dif.ir_valid = 1'b0;
        tests_run++; if (dif.dec_valid !== 1'b1) begin tests_failed++; $display("FAIL add_valid: got %0b want 1", dif.dec_valid); end
        tests_run++; if (dif.dec_opcode !== 6'b010001) begin tests_failed++; $display("FAIL add_opcode: got %b want 010001", dif.dec_opcode); end
        tests_run++; if (dif.dec_rd !== 3'd5) begin tests_failed++; $display("FAIL add_rd: got %0d want 5", dif.dec_rd); end
        tests_run++; if (dif.dec_rs1 !== 3'd1) begin tests_failed++; $display("FAIL add_rs1: got %0d want 1", dif.dec_rs1); end
        tests_run++; if (dif.dec_rs2 !== 3'd4) begin tests_failed++; $display("FAIL add_rs2: got %0d want 4", dif.dec_rs2); end
        tests_run++; if (dif.dec_writes_status !== 1'b1) begin tests_failed++; $display("FAIL add_ws: got %0b want 1", dif.dec_writes_status); end
        tests_run++; if (dif.dec_instruction !== 16'h4698) begin tests_failed++; $display("FAIL add_instr: got %h want 4698", dif.dec_instruction); end
        tick();
        tests_run++; if (dif.dec_valid !== 1'b0) begin tests_failed++; $display("FAIL add_consumed: got %0b want 0", dif.dec_valid); end
        $display("[TB] add: instr=4698 opcode=%b rd=%0d rs1=%0d rs2=%0d", 6'b010001, 5, 1, 4);
    endtask

    task automatic test_backpressure();
        logic [15:0] a, b;
        a = {6'b010101, 3'd2, 3'd3, 3'd6, 1'b0};
        b = {6'b010110, 3'd1, 3'd2, 3'd3, 1'b1};
        dif.ir_data = a; dif.ir_valid = 1'b1; dif.dec_ready = 1'b0;
        tick();
        tests_run++; if (dif.dec_instruction !== a) begin tests_failed++; $display("FAIL bp_load_a: got %h want %h", dif.dec_instruction, a); end
        tests_run++; if (dif.dec_writes_status !== 1'b0) begin tests_failed++; $display("FAIL bp_gha_ws: got %0b want 0", dif.dec_writes_status); end
        dif.ir_data = b;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests_run++; if (dif.ir_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_%0d: got %0b want 0", i, dif.ir_ready); end
            tick();
            tests_run++; if (dif.dec_instruction !== a || dif.dec_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold_%0d: got %h/%0b want %h/1", i, dif.dec_instruction, dif.dec_valid, a); end
        end
        dif.dec_ready = 1'b1;
        #1;
        tests_run++; if (dif.ir_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %0b want 1", dif.ir_ready); end
        tick();
        dif.ir_valid = 1'b0;
        tests_run++; if (dif.dec_instruction !== b || dif.dec_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_load_b: got %h/%0b want %h/1", dif.dec_instruction, dif.dec_valid, b); end
        tests_run++; if (dif.dec_writes_status !== 1'b0) begin tests_failed++; $display("FAIL bp_ghs_ws: got %0b want 0", dif.dec_writes_status); end
        tick();
        tests_run++; if (dif.dec_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got %0b want 0", dif.dec_valid); end
        $display("[TB] backpressure: held %h for 3 cycles then accepted %h", a, b);
    endtask

    task automatic test_mul();
        logic [15:0] m, c;
        m = {6'b100001, 3'd7, 3'd2, 3'd3, 1'b0};
        c = 16'h4698;
        dif.ir_data = m; dif.ir_valid = 1'b1; dif.dec_ready = 1'b1;
        tick();
        dif.ir_data = c;
        #1;
        tests_run++; if (dif.dec_valid !== 1'b1 || dif.dec_uop !== 1'b0 || dif.dec_rd !== 3'd7) begin tests_failed++; $display("FAIL mul_uop0: got v=%0b uop=%0b rd=%0d want v=1 uop=0 rd=7", dif.dec_valid, dif.dec_uop, dif.dec_rd); end
`ifdef DECODER_MUL_SPLIT_EN
        tests_run++; if (dif.ir_ready !== 1'b0) begin tests_failed++; $display("FAIL mul_ready_uop0: got %0b want 0", dif.ir_ready); end
        tick();
        tests_run++; if (dif.dec_valid !== 1'b1 || dif.dec_uop !== 1'b1 || dif.dec_rd !== 3'd0) begin tests_failed++; $display("FAIL mul_uop1: got v=%0b uop=%0b rd=%0d want v=1 uop=1 rd=0", dif.dec_valid, dif.dec_uop, dif.dec_rd); end
        tests_run++; if (dif.dec_opcode !== 6'b100001 || dif.dec_rs1 !== 3'd2 || dif.dec_rs2 !== 3'd3) begin tests_failed++; $display("FAIL mul_uop1_fields: got op=%b rs1=%0d rs2=%0d want 100001/2/3", dif.dec_opcode, dif.dec_rs1, dif.dec_rs2); end
        tests_run++; if (dif.ir_ready !== 1'b0) begin tests_failed++; $display("FAIL mul_ready_uop1: got %0b want 0", dif.ir_ready); end
        tick();
        tests_run++; if (dif.dec_valid !== 1'b0 || dif.ir_ready !== 1'b1) begin tests_failed++; $display("FAIL mul_done: got v=%0b rdy=%0b want v=0 rdy=1", dif.dec_valid, dif.ir_ready); end
`else
        tests_run++; if (dif.ir_ready !== 1'b1) begin tests_failed++; $display("FAIL mul_single_ready: got %0b want 1", dif.ir_ready); end
`endif
        tick();
        dif.ir_valid = 1'b0;
        tests_run++; if (dif.dec_instruction !== c || dif.dec_uop !== 1'b0) begin tests_failed++; $display("FAIL mul_next: got %h uop=%0b want %h uop=0", dif.dec_instruction, dif.dec_uop, c); end
        tick();
        $display("[TB] mul: rd=7 issued, following instr %h accepted", c);
    endtask

    task automatic test_illegal();
        logic [15:0] last_op, ill1, ill2;
        last_op = {6'b111000, 3'd4, 3'd5, 3'd6, 1'b1};
        ill1    = {6'b111001, 10'h155};
        ill2    = {6'b111101, 10'h0AB};
        dif.ir_data = ill2; dif.ir_valid = 1'b1; dif.dec_ready = 1'b1;
        #1;
        tests_run++; if (dif.ir_ready !== 1'b1) begin tests_failed++; $display("FAIL ill_ready: got %0b want 1", dif.ir_ready); end
        tick();
        dif.ir_valid = 1'b0;
        tests_run++; if (dif.illegal_op !== 1'b1 || dif.dec_valid !== 1'b0) begin tests_failed++; $display("FAIL ill_pulse: got ill=%0b v=%0b want ill=1 v=0", dif.illegal_op, dif.dec_valid); end
        tick();
        tests_run++; if (dif.illegal_op !== 1'b0) begin tests_failed++; $display("FAIL ill_one_cycle: got %0b want 0", dif.illegal_op); end
        dif.ir_data = last_op; dif.ir_valid = 1'b1;
        tick();
        tests_run++; if (dif.dec_valid !== 1'b1 || dif.dec_opcode !== 6'b111000 || dif.illegal_op !== 1'b0) begin tests_failed++; $display("FAIL ill_last_legal: got v=%0b op=%b ill=%0b want 1/111000/0", dif.dec_valid, dif.dec_opcode, dif.illegal_op); end
        dif.ir_data = ill1;
        tick();
        dif.ir_valid = 1'b0;
        tests_run++; if (dif.dec_valid !== 1'b0 || dif.illegal_op !== 1'b1) begin tests_failed++; $display("FAIL ill_after_consume: got v=%0b ill=%0b want v=0 ill=1", dif.dec_valid, dif.illegal_op); end
        tests_run++; if (dif.dec_instruction !== last_op) begin tests_failed++; $display("FAIL ill_not_loaded: got %h want %h", dif.dec_instruction, last_op); end
        tick();
        $display("[TB] illegal: %h and %h dropped, boundary %h decoded", ill2, ill1, last_op);
    endtask

    task automatic test_flush();
        logic [15:0] m;
        m = {6'b100001, 3'd3, 3'd1, 3'd2, 1'b0};
        dif.ir_data = m; dif.ir_valid = 1'b1; dif.dec_ready = 1'b1;
        tick();
        tests_run++; if (dif.dec_valid !== 1'b1) begin tests_failed++; $display("FAIL fl_pre_valid: got %0b want 1", dif.dec_valid); end
        dif.ir_data = 16'h4698; dif.flush = 1'b1;
        #1;
        tests_run++; if (dif.ir_ready !== 1'b0) begin tests_failed++; $display("FAIL fl_ready: got %0b want 0", dif.ir_ready); end
        tick();
        dif.flush = 1'b0; dif.ir_valid = 1'b0;
        #1;
        tests_run++; if (dif.dec_valid !== 1'b0) begin tests_failed++; $display("FAIL fl_valid: got %0b want 0", dif.dec_valid); end
        tests_run++; if (dif.dec_instruction !== m) begin tests_failed++; $display("FAIL fl_not_accepted: got %h want %h", dif.dec_instruction, m); end
        tests_run++; if (dif.ir_ready !== 1'b1) begin tests_failed++; $display("FAIL fl_run_state: got %0b want 1", dif.ir_ready); end
        $display("[TB] flush: MUL %h discarded, concurrent instr rejected", m);
    endtask

    task automatic test_reset_mid();
        dif.ir_data = 16'h4698; dif.ir_valid = 1'b1; dif.dec_ready = 1'b0;
        tick();
        dif.ir_valid = 1'b0;
        tests_run++; if (dif.dec_valid !== 1'b1) begin tests_failed++; $display("FAIL rm_pre_valid: got %0b want 1", dif.dec_valid); end
        reset_n = 1'b0;
        #1;
        tests_run++; if (dif.ir_ready !== 1'b0) begin tests_failed++; $display("FAIL rm_ready_low: got %0b want 0", dif.ir_ready); end
        tick();
        tests_run++; if (dif.dec_valid !== 1'b0 || dif.dec_instruction !== 16'h0 || dif.dec_opcode !== 6'h0) begin tests_failed++; $display("FAIL rm_clear_a: got v=%0b instr=%h op=%h want 0/0000/00", dif.dec_valid, dif.dec_instruction, dif.dec_opcode); end
        tests_run++; if (dif.dec_rd !== 3'd0 || dif.dec_rs1 !== 3'd0 || dif.dec_rs2 !== 3'd0) begin tests_failed++; $display("FAIL rm_clear_regs: got %0d/%0d/%0d want 0/0/0", dif.dec_rd, dif.dec_rs1, dif.dec_rs2); end
        tests_run++; if (dif.dec_writes_status !== 1'b0 || dif.dec_uop !== 1'b0 || dif.illegal_op !== 1'b0) begin tests_failed++; $display("FAIL rm_clear_b: got ws=%0b uop=%0b ill=%0b want 0/0/0", dif.dec_writes_status, dif.dec_uop, dif.illegal_op); end
        reset_n = 1'b1; dif.dec_ready = 1'b1;
        #1;
        tests_run++; if (dif.ir_ready !== 1'b1) begin tests_failed++; $display("FAIL rm_ready_high: got %0b want 1", dif.ir_ready); end
        dif.ir_data = {6'b100001, 3'd7, 3'd2, 3'd3, 1'b0}; dif.ir_valid = 1'b1;
        tick();
        dif.ir_valid = 1'b0; reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tests_run++; if (dif.dec_valid !== 1'b0 || dif.ir_ready !== 1'b1) begin tests_failed++; $display("FAIL rm_mul_abandon: got v=%0b rdy=%0b want v=0 rdy=1", dif.dec_valid, dif.ir_ready); end
        $display("[TB] reset_mid: entry cleared, MUL second micro-op abandoned");
    endtask

    initial begin
        reset_n = 1'b0;
        dif.ir_valid = 1'b0; dif.ir_data = '0; dif.flush = 1'b0; dif.dec_ready = 1'b0;
        test_reset();
        test_add();
        test_backpressure();
        test_mul();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
